// File: rtl/opbomp_frame_assembler.sv
// Serial-to-parallel sample packer for the OMP decoder input.
// One assembly buffer plus one output holding register.
module opbomp_frame_assembler #(
  parameter int N          = 24,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [N*DATA_WIDTH-1:0] x_out,
  output logic                    x_valid,
  input  logic                    x_ready,
  output logic                    frame_err,
  output logic [CNT_WIDTH-1:0]    frame_count
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0]           idx;
  logic                    a_full;
  logic [N*DATA_WIDTH-1:0] asm_q;
  logic [N*DATA_WIDTH-1:0] asm_next;

  logic accept;
  logic consume;
  logic holder_free;
  logic is_last;

  assign s_ready     = !a_full;
  assign accept      = s_valid && !a_full;
  assign consume     = x_valid && x_ready;
  assign holder_free = !x_valid || x_ready;
  assign is_last     = (idx == LAST);

  // Buffer view including the beat accepted this cycle
  always_comb begin
    asm_next = asm_q;
    if (accept)
      asm_next[idx*DATA_WIDTH +: DATA_WIDTH] = s_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      a_full      <= 1'b0;
      asm_q       <= '0;
      x_out       <= '0;
      x_valid     <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_err <= accept && (s_last != is_last);
      if (accept) begin
        asm_q <= asm_next;
        idx   <= (is_last || s_last) ? '0 : idx + 1'b1;
      end
      if (a_full && holder_free) begin
        x_out       <= asm_q;
        x_valid     <= 1'b1;
        a_full      <= 1'b0;
        frame_count <= frame_count + 1'b1;
      end else if (accept && is_last && holder_free) begin
        x_out       <= asm_next;
        x_valid     <= 1'b1;
        frame_count <= frame_count + 1'b1;
      end else begin
        if (accept && is_last)
          a_full <= 1'b1;
        if (consume)
          x_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_opbomp_frame_assembler.sv
// Directed-step bench for opbomp_frame_assembler.
// Immediate assertions compare outputs against hand-computed values.
module tb_opbomp_frame_assembler;

  localparam int N  = 24;
  localparam int DW = 16;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   s_data;
  logic            s_valid;
  logic            s_last;
  logic            s_ready;
  logic [N*DW-1:0] x_out;
  logic            x_valid;
  logic            x_ready;
  logic            frame_err;
  logic [CW-1:0]   frame_count;

  int n_assert = 0;
  int n_fail   = 0;
  int errs     = 0;
  int vpulses  = 0;
  int rdy_drop = 0;

  opbomp_frame_assembler #(
    .N(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready),
    .x_out(x_out), .x_valid(x_valid),
    .x_ready(x_ready), .frame_err(frame_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    if (!s_ready) rdy_drop++;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (frame_err) errs++;
    if (x_valid) vpulses++;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick();
    tick();
    reset    = 1'b0;
    errs     = 0;
    vpulses  = 0;
    rdy_drop = 0;
  endtask

  function automatic logic [DW-1:0] smp(input int k);
    return x_out[k*DW +: DW];
  endfunction

  initial begin
    reset   = 1'b1;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    x_ready = 1'b1;

    // Basic frame
    do_reset();
    chk("rst_x_valid", 32'(x_valid), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_x_out0", 32'(smp(0)), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    for (int i = 1; i <= N; i++) begin
      send(DW'(i), i == N);
      if (i == N - 1) chk("basic_early", 32'(x_valid), 32'd0);
    end
    chk("basic_valid", 32'(x_valid), 32'd1);
    chk("basic_s0", 32'(smp(0)), 32'd1);
    chk("basic_s23", 32'(smp(23)), 32'd24);
    chk("basic_s11", 32'(smp(11)), 32'd12);
    chk("basic_count", 32'(frame_count), 32'd1);
    chk("basic_err", 32'(errs), 32'd0);
    tick();
    chk("basic_consumed", 32'(x_valid), 32'd0);

    // Back-to-back
    do_reset();
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < N; k++)
        send(DW'(f * 100 + k), k == N - 1);
    chk("b2b_pulses", 32'(vpulses), 32'd3);
    chk("b2b_ready", 32'(rdy_drop), 32'd0);
    chk("b2b_count", 32'(frame_count), 32'd3);
    chk("b2b_s0", 32'(smp(0)), 32'd200);
    chk("b2b_s23", 32'(smp(23)), 32'd223);
    chk("b2b_err", 32'(errs), 32'd0);

    // Backpressure
    do_reset();
    x_ready = 1'b0;
    for (int k = 0; k < N; k++) send(DW'(k + 1), k == N - 1);
    for (int k = 0; k < N; k++) send(DW'(k + 201), k == N - 1);
    chk("bp_s_ready", 32'(s_ready), 32'd0);
    chk("bp_held_s0", 32'(smp(0)), 32'd1);
    chk("bp_valid", 32'(x_valid), 32'd1);
    chk("bp_count1", 32'(frame_count), 32'd1);
    chk("bp_ready_drop", 32'(rdy_drop), 32'd0);
    s_data  = 16'h0999;
    s_valid = 1'b1;
    s_last  = 1'b1;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("bp_stall_err", 32'(frame_err), 32'd0);
    chk("bp_stall_rdy", 32'(s_ready), 32'd0);
    chk("bp_stall_s0", 32'(smp(0)), 32'd1);
    x_ready = 1'b1;
    tick();
    x_ready = 1'b0;
    chk("bp_rel_valid", 32'(x_valid), 32'd1);
    chk("bp_rel_s0", 32'(smp(0)), 32'd201);
    chk("bp_rel_s23", 32'(smp(23)), 32'd224);
    chk("bp_rel_count", 32'(frame_count), 32'd2);
    chk("bp_rel_rdy", 32'(s_ready), 32'd1);
    chk("bp_err", 32'(errs), 32'd0);
    x_ready = 1'b1;
    tick();
    chk("bp_drain", 32'(x_valid), 32'd0);

    // Short frame
    do_reset();
    for (int k = 0; k < 10; k++) send(DW'(k + 50), k == 9);
    chk("short_err", 32'(frame_err), 32'd1);
    chk("short_valid", 32'(x_valid), 32'd0);
    tick();
    chk("short_err_once", 32'(frame_err), 32'd0);
    for (int k = 0; k < N; k++) send(DW'(k + 301), k == N - 1);
    chk("short_after_s0", 32'(smp(0)), 32'd301);
    chk("short_after_s23", 32'(smp(23)), 32'd324);
    chk("short_after_valid", 32'(x_valid), 32'd1);
    chk("short_count", 32'(frame_count), 32'd1);
    chk("short_errs", 32'(errs), 32'd1);
    tick();

    // Missing s_last
    errs = 0;
    for (int k = 0; k < N; k++) begin
      send(DW'(k + 401), 1'b0);
      if (k == N - 2) chk("nolast_no_err", 32'(frame_err), 32'd0);
    end
    chk("nolast_err", 32'(frame_err), 32'd1);
    chk("nolast_valid", 32'(x_valid), 32'd1);
    chk("nolast_s23", 32'(smp(23)), 32'd424);
    chk("nolast_count", 32'(frame_count), 32'd2);
    tick();
    chk("nolast_err_once", 32'(frame_err), 32'd0);
    chk("nolast_errs", 32'(errs), 32'd1);

    // Reset mid-frame
    for (int k = 0; k < 12; k++) send(DW'(k + 700), 1'b0);
    do_reset();
    chk("mid_rst_valid", 32'(x_valid), 32'd0);
    chk("mid_rst_count", 32'(frame_count), 32'd0);
    for (int k = 0; k < N; k++) send(DW'(k + 100), k == N - 1);
    chk("mid_s0", 32'(smp(0)), 32'd100);
    chk("mid_s23", 32'(smp(23)), 32'd123);
    chk("mid_count", 32'(frame_count), 32'd1);
    chk("mid_errs", 32'(errs), 32'd0);

    // Load and consume in the same cycle
    do_reset();
    x_ready = 1'b0;
    for (int k = 0; k < N; k++) send(DW'(k + 1), k == N - 1);
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) x_ready = 1'b1;
      send(DW'(k + 501), k == N - 1);
    end
    chk("swap_valid", 32'(x_valid), 32'd1);
    chk("swap_s0", 32'(smp(0)), 32'd501);
    chk("swap_count", 32'(frame_count), 32'd2);
    chk("swap_rdy", 32'(s_ready), 32'd1);
    tick();
    chk("swap_drain", 32'(x_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/opbomp_frame_assembler.md
Name: opbomp_frame_assembler

Overview:
- Upstream input stage of the OMP decoder.
- Accepts received-signal samples serially, one DATA_WIDTH word per beat on a valid/ready stream.
- Packs N samples into the flat N*DATA_WIDTH vector consumed by the decoder's x input, and presents that vector with a valid/ready handshake.
- Has one assembly buffer plus one output holding register, so a full-rate stream (1 sample/cycle) is sustained whenever the consumer is ready.

Parameters:
- N, 24, samples per frame; equals the decoder's N.
- DATA_WIDTH, 16, bits per sample (two's complement, passed through unmodified).
- CNT_WIDTH, 16, width of the completed-frame counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- s_data  input  DATA_WIDTH  incoming sample.
- s_valid  input  1  s_data valid.
- s_last  input  1  marks the final sample of a frame; qualified by s_valid&&s_ready.
- s_ready  output  1  assembler can accept a sample this cycle.
- x_out  output  N*DATA_WIDTH  assembled frame; sample k of the frame at bits [k*DATA_WIDTH +: DATA_WIDTH].
- x_valid  output  1  x_out holds a complete frame.
- x_ready  input  1  consumer takes x_out when x_valid&&x_ready.
- frame_err  output  1  one-cycle pulse on a framing error.
- frame_count  output  CNT_WIDTH  number of frames delivered to x_out; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (synchronous, any cycle, including mid-frame): idx=0, a_full=0, x_valid=0, x_out=0, frame_err=0, frame_count=0, assembly buffer=0. The partial frame is discarded. s_ready=1 in the first cycle after reset deasserts.
- Accept: a beat is accepted when s_valid&&s_ready. The sample is written to assembly slot idx, then idx increments.
- s_ready = !a_full. It is combinational from registered state only, with no path from s_valid or x_ready.
- Frame complete: an accepted beat with idx==N-1. Next-cycle action depends on the holding register:
  - Holding register free (x_valid==0, or x_valid&&x_ready this cycle): the frame, including the current sample, loads into x_out; x_valid=1 next cycle; idx=0.
  - Otherwise: a_full=1 and idx=0. No sample is accepted until the holding register frees. In that cycle the assembly buffer moves to x_out, x_valid stays 1, and a_full clears next cycle.
- Consume: x_valid&&x_ready with nothing to load clears x_valid next cycle. x_out holds its last value; it is don't-care while x_valid=0 but must not glitch while x_valid=1.
- Latency: last sample accepted at cycle T gives x_valid=1 at T+1 when the holder is free.
- frame_count increments by 1 on each load into x_out, not on consumption.
- Framing rules, for accepted beats only:
  - s_last=1 with idx<N-1: partial frame dropped; idx=0; frame_err=1 next cycle; nothing emitted.
  - idx==N-1 with s_last=0: frame still completes normally; frame_err=1 next cycle.
  - idx==N-1 with s_last=1: normal completion; no error.
- frame_err is high for exactly one cycle per offending beat.
- Simultaneous load and consume in one cycle: the new frame replaces the old one, x_valid stays 1, no bubble.
- While a_full=1, s_valid and s_last are ignored, and no error is raised for beats presented during stall.
- Throughput: with x_ready held 1, N accepted samples in N consecutive cycles produce one frame every N cycles, and s_ready never deasserts.
- No combinational path from any input to any output except none; all outputs are registered or derived from registers.

Test Plan:
- Basic frame: reset 2 cycles, then stream samples 1..24 (s_last on the 24th), x_ready=1 → x_valid high 1 cycle after the 24th beat; x_out[15:0]=1, x_out[383:368]=24; frame_count=1; frame_err never high.
- Back-to-back: 3 frames streamed continuously, x_ready=1 → s_ready stays 1 throughout; x_valid pulses every 24 cycles; frame_count=3.
- Backpressure: x_ready=0, stream 2 full frames → first frame held on x_out; s_ready=0 after the 48th beat; raising x_ready for 1 cycle → second frame loads the next cycle, x_valid stays 1, s_ready returns to 1.
- Short frame: s_last on the 10th sample → frame_err pulses once; no x_valid; the next 24 samples form a correct frame with sample0 at bits [15:0].
- Missing s_last: 24 samples with s_last=0 → frame emitted and frame_err pulses once in the same cycle as x_valid rises.
- Reset mid-frame: reset asserted after 12 samples, then 24 fresh samples 100..123 → x_out sample0=100; frame_count=1; no error.
